progmem_boot: RTL and testbench

PROGMEM_BOOT -- requirements
Module: progmem_boot

---
 rtl/progmem_boot.sv | 144 ++++++++++++++
 tb/tb_progmem_boot.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/progmem_boot.sv
// Loadable program memory: a boot loader fills the array over a valid/ready stream, then serves 1-cycle-latency fetches.
// Optional per-word even parity is enabled by defining PROGMEM_PARITY_EN.
module progmem_boot #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_perr,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              ld_perr_inj,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
`ifdef PROGMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_perr_q, fetch_perr_d;
  logic              ld_done_q, ld_done_d;

  logic              mem_we;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [MEM_W-1:0]  wr_word, rd_word;
  logic              rd_hit;
  logic              rd_perr;

  // ld_count doubles as the write pointer: words are always stored densely from address 0.
  assign wr_idx  = ld_count_q[IDX_W-1:0];
  assign rd_idx  = fetch_addr[IDX_W-1:0];
  assign rd_word = mem[rd_idx];
  assign rd_hit  = {1'b0, fetch_addr} < ld_count_q;

`ifdef PROGMEM_PARITY_EN
  assign wr_word = {(^ld_data) ^ ld_perr_inj, ld_data};
  assign rd_perr = rd_word[DATA_W] ^ (^rd_word[DATA_W-1:0]);
`else
  logic unused_perr_inj;
  assign unused_perr_inj = ld_perr_inj;
  assign wr_word         = ld_data;
  assign rd_perr         = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d       = state_q;
    ld_count_d    = ld_count_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    fetch_perr_d  = 1'b0;
    ld_done_d     = 1'b0;
    mem_we        = 1'b0;
    ld_ready      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d    = LOAD;
          ld_count_d = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          ld_count_d = '0;          // restart; a word offered this cycle is dropped
        end else if (ld_valid) begin
          mem_we     = 1'b1;
          ld_count_d = ld_count_q + 1'b1;
          if (ld_last || ld_count_q == LAST_IDX) begin
            state_d   = RUN;
            ld_done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (ld_start) begin
          state_d    = LOAD;
          ld_count_d = '0;
        end else if (fetch_en) begin
          fetch_valid_d = 1'b1;
          if (rd_hit) begin
            fetch_data_d = rd_word[DATA_W-1:0];
            fetch_perr_d = rd_perr;
          end else begin
            fetch_data_d = '1;      // HALT encoding for unloaded addresses
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; ld_count alone decides which words are visible.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= wr_word;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ld_count_q    <= '0;
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
      fetch_perr_q  <= 1'b0;
      ld_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ld_count_q    <= ld_count_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_perr_q  <= fetch_perr_d;
      ld_done_q     <= ld_done_d;
    end
  end

  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_perr  = fetch_perr_q;
  assign ld_done     = ld_done_q;
  assign ld_count    = ld_count_q;

endmodule

// File: tb/tb_progmem_boot.sv
// Directed bench for progmem_boot: a default-depth instance plus a DEPTH=4 instance sharing one stimulus stream.
module tb_progmem_boot;

  localparam int AW = 8;
  localparam int DW = 16;
`ifdef PROGMEM_PARITY_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_perr_inj = 1'b0;

  logic [DW-1:0] fetch_data, fetch_data4;
  logic          fetch_valid, fetch_valid4;
  logic          fetch_perr, fetch_perr4;
  logic          ld_ready, ld_ready4;
  logic          ld_done, ld_done4;
  logic [AW:0]   ld_count, ld_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  progmem_boot #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_perr(fetch_perr),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_perr_inj(ld_perr_inj), .ld_ready(ld_ready), .ld_done(ld_done), .ld_count(ld_count)
  );

  progmem_boot #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data4), .fetch_valid(fetch_valid4), .fetch_perr(fetch_perr4),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_perr_inj(ld_perr_inj), .ld_ready(ld_ready4), .ld_done(ld_done4), .ld_count(ld_count4)
  );

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          valid;
    logic          perr;
  } fvec_t;

  fvec_t vec [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last, input logic inj);
    ld_valid = 1'b1; ld_data = d; ld_last = last; ld_perr_inj = inj;
    step();
    ld_valid = 1'b0; ld_last = 1'b0; ld_perr_inj = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    fetch_en = 1'b1; fetch_addr = a;
    step();
    fetch_en = 1'b0;
  endtask

  initial begin
    // {en, addr, expected data, expected valid, expected perr} after the 3-word image
    vec[0] = '{1'b1, 8'd1,   16'hA00A, 1'b1, 1'b0};
    vec[1] = '{1'b1, 8'd0,   16'h80FF, 1'b1, 1'b0};
    vec[2] = '{1'b0, 8'd2,   16'h80FF, 1'b0, 1'b0};
    vec[3] = '{1'b1, 8'd5,   16'hFFFF, 1'b1, 1'b0};
    vec[4] = '{1'b1, 8'd2,   16'hF0FF, 1'b1, EXP_PERR};
    vec[5] = '{1'b1, 8'd3,   16'hFFFF, 1'b1, 1'b0};
    vec[6] = '{1'b1, 8'd255, 16'hFFFF, 1'b1, 1'b0};
    vec[7] = '{1'b0, 8'd0,   16'hFFFF, 1'b0, 1'b0};

    #12;
    check("rst fetch_data", 32'(fetch_data), 32'h0);
    check("rst fetch_valid", 32'(fetch_valid), 32'h0);
    check("rst ld_ready", 32'(ld_ready), 32'h0);
    check("rst ld_count", 32'(ld_count), 32'h0);
    rst_n = 1'b1;

    // IDLE ignores fetches
    fetch(8'd0);
    check("idle fetch_valid", 32'(fetch_valid), 32'h0);
    check("idle ld_ready", 32'(ld_ready), 32'h0);

    ld_start = 1'b1; step(); ld_start = 1'b0;
    check("load ld_ready", 32'(ld_ready), 32'h1);
    check("load ld_count0", 32'(ld_count), 32'h0);
    load_word(16'h80FF, 1'b0, 1'b0);
    check("load ld_count1", 32'(ld_count), 32'h1);
    check("load no done", 32'(ld_done), 32'h0);
    load_word(16'hA00A, 1'b0, 1'b0);
    load_word(16'hF0FF, 1'b1, 1'b1);
    check("ld_done pulse", 32'(ld_done), 32'h1);
    check("ld_count 3", 32'(ld_count), 32'h3);
    check("run ld_ready", 32'(ld_ready), 32'h0);
    step();
    check("ld_done one cycle", 32'(ld_done), 32'h0);

    for (int i = 0; i < 8; i++) begin
      fetch_en = vec[i].en; fetch_addr = vec[i].addr;
      step();
      check($sformatf("vec%0d data", i), 32'(fetch_data), 32'(vec[i].data));
      check($sformatf("vec%0d valid", i), 32'(fetch_valid), 32'(vec[i].valid));
      check($sformatf("vec%0d perr", i), 32'(fetch_perr), 32'(vec[i].perr));
    end
    fetch_en = 1'b0;

    // ld_start beats a simultaneous fetch
    fetch_en = 1'b1; fetch_addr = 8'd0; ld_start = 1'b1;
    step();
    fetch_en = 1'b0; ld_start = 1'b0;
    check("collide fetch_valid", 32'(fetch_valid), 32'h0);
    check("collide ld_ready", 32'(ld_ready), 32'h1);
    check("collide ld_count", 32'(ld_count), 32'h0);

    // restart inside LOAD discards the word offered with ld_start
    load_word(16'h1111, 1'b0, 1'b0);
    ld_start = 1'b1;
    load_word(16'h2222, 1'b0, 1'b0);
    ld_start = 1'b0;
    check("restart ld_count", 32'(ld_count), 32'h0);
    load_word(16'h3333, 1'b1, 1'b0);
    check("restart ld_count1", 32'(ld_count), 32'h1);
    fetch(8'd0);
    check("restart word0", 32'(fetch_data), 32'h3333);
    fetch(8'd1);
    check("stale word hidden", 32'(fetch_data), 32'hFFFF);
    check("stale valid", 32'(fetch_valid), 32'h1);

    // reset in the middle of a 4-word load
    ld_start = 1'b1; step(); ld_start = 1'b0;
    load_word(16'h4444, 1'b0, 1'b0);
    load_word(16'h5555, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst ld_count", 32'(ld_count), 32'h0);
    check("midrst ld_ready", 32'(ld_ready), 32'h0);
    check("midrst fetch_data", 32'(fetch_data), 32'h0);
    check("midrst ld_done", 32'(ld_done), 32'h0);
    #3 rst_n = 1'b1;
    fetch(8'd0);
    check("postrst fetch ignored", 32'(fetch_valid), 32'h0);
    check("postrst data", 32'(fetch_data), 32'h0);
    ld_start = 1'b1; step(); ld_start = 1'b0;
    load_word(16'h6666, 1'b1, 1'b0);
    fetch(8'd0);
    check("postrst reload", 32'(fetch_data), 32'h6666);
    fetch(8'd1);
    check("postrst abandoned word", 32'(fetch_data), 32'hFFFF);

    // truncation at DEPTH on the 4-deep instance
    ld_start = 1'b1; step(); ld_start = 1'b0;
    for (int w = 0; w < 6; w++) begin
      load_word(16'hC000 + 16'(w), 1'b0, 1'b0);
      if (w == 3) begin
        check("trunc ld_done", 32'(ld_done4), 32'h1);
        check("trunc ready off", 32'(ld_ready4), 32'h0);
      end
    end
    check("trunc ld_count", 32'(ld_count4), 32'h4);
    check("trunc ld_ready", 32'(ld_ready4), 32'h0);
    check("deep still loading", 32'(ld_count), 32'h6);
    fetch(8'd3);
    check("trunc addr3", 32'(fetch_data4), 32'hC003);
    check("trunc valid", 32'(fetch_valid4), 32'h1);
    fetch(8'd4);
    check("trunc addr4 halt", 32'(fetch_data4), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
